// File: rtl/ram_fifo_sync.sv
// Synchronous RAM-backed FIFO: registered read data, occupancy count and level flags.
// Sticky overflow/underflow flags are built only when RAM_FIFO_ERR_EN is defined.
module ram_fifo_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  input  logic              rd,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_ok = rd && !empty;
  assign wr_ok = we && (!full || rd_ok);

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // NOTE: storage has no reset; stale words are unreachable because the
  // pointers and count are cleared, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= d;
    end
  end

  // NOTE: non-blocking assignments make a same-slot write and read (full FIFO)
  // return the old word, and keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= rd_ok;
      if (rd_ok) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RAM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && !wr_ok) overflow  <= 1'b1;
      if (rd && !rd_ok) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_sync.sv
// Self-checking bench for ram_fifo_sync: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_ram_fifo_sync;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [DATA_W-1:0] d;
  logic              rd;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  ram_fifo_sync #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .d           (d),
    .rd          (rd),
    .q           (q),
    .q_valid     (q_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as a queue, plus expected registered outputs.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q;
  logic              exp_qv;
  logic              exp_ovf;
  logic              exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [DATA_W-1:0] wd,
                            input logic re);
    bit rd_acc;
    bit wr_acc;
    if (r) begin
      model_q.delete();
      exp_q   = '0;
      exp_qv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      rd_acc = re && (model_q.size() > 0);
      wr_acc = w && (model_q.size() < DEPTH || rd_acc);
      exp_qv = rd_acc;
      if (rd_acc) exp_q = model_q.pop_front();
      if (wr_acc) model_q.push_back(wd);
      if (w && !wr_acc) exp_ovf = 1'b1;
      if (re && !rd_acc) exp_unf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int n;
    n = model_q.size();
    check("q",            32'(q),            32'(exp_q));
    check("q_valid",      32'(q_valid),      32'(exp_qv));
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
`ifdef RAM_FIFO_ERR_EN
    check("overflow",     32'(overflow),     32'(exp_ovf));
    check("underflow",    32'(underflow),    32'(exp_unf));
`else
    check("overflow",     32'(overflow),     32'(0));
    check("underflow",    32'(underflow),    32'(0));
`endif
  endtask

  // One clock: drive on the falling edge, advance the model, compare after the rising edge.
  task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] wd, input logic re);
    @(negedge clk);
    rst = r;
    we  = w;
    d   = wd;
    rd  = re;
    model_step(r, w, wd, re);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    d   = '0;
    rd  = 1'b0;
    exp_q = '0; exp_qv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;

    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Fill with 1..8, then drain.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, DATA_W'(i), 0);
    check("fill_full", 32'(full), 32'(1));
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
    check("drain_last_q", 32'(q), 32'(8));
    step(0, 0, 0, 0);
    check("drain_empty", 32'(empty), 32'(1));

    // Wrap: 5 in/out, then 6 in/out across the pointer boundary.
    for (int i = 0; i < 5; i++) step(0, 1, DATA_W'(8'h10 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, DATA_W'(8'h20 + i), 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check("wrap_last_q", 32'(q), 32'(8'h25));

    // Full with simultaneous write/read, then drain so 0xAA comes out last.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, DATA_W'(8'h30 + i), 0);
    step(0, 1, 8'hAA, 1);
    check("full_wr_rd_q", 32'(q), 32'(8'h31));
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
    check("aa_last", 32'(q), 32'(8'hAA));

    // Empty with simultaneous write/read: only the write is taken.
    step(0, 1, 8'h55, 1);
    check("empty_wr_rd_qv", 32'(q_valid), 32'(0));
    step(0, 0, 0, 1);
    check("empty_wr_rd_q", 32'(q), 32'(8'h55));

    // Error flags: read while empty, write while full, persistence, reset clear.
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, DATA_W'(8'h40 + i), 0);
    step(0, 1, 8'hEE, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Mid-stream reset with count 4, then fresh write/read.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, DATA_W'(8'h60 + i), 0);
    step(1, 1, 8'h77, 1);
    check("rst_count", 32'(count), 32'(0));
    step(0, 1, 8'h99, 0);
    step(0, 0, 0, 1);
    check("post_rst_q", 32'(q), 32'(8'h99));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 55),
           DATA_W'($urandom),
           ($urandom_range(0, 99) < 50));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
